// File: rtl/cfo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cfo_pkg                                                              |
// | Shared constants and complex-sample packing helpers for the CFO      |
// | correction path. A complex word carries imag in the upper half and   |
// | real in the lower half, both signed.                                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cfo_pkg;

   localparam int CFO_DW_DEF   = 20;
   localparam int PHASE_DW_DEF = 24;

   // Angle of pi in CFO units and a full turn in accumulator units.
   localparam longint PI_NORM      = longint'(1) << (CFO_DW_DEF - 1);
   localparam longint TWO_PI_PHASE = longint'(1) << PHASE_DW_DEF;

   // Real part of a dw-bit complex word, sign-extended to 64 bits.
   function automatic logic signed [63:0] cplx_re(input logic [63:0] word, input int dw);
      return signed'(word << (64 - dw / 2)) >>> (64 - dw / 2);
   endfunction

   // Imag part of a dw-bit complex word, sign-extended to 64 bits.
   function automatic logic signed [63:0] cplx_im(input logic [63:0] word, input int dw);
      return signed'(word << (64 - dw)) >>> (64 - dw / 2);
   endfunction

   // Pack re/im halves into a dw-bit word; caller truncates to dw bits.
   function automatic logic [63:0] cplx_pack(input logic [63:0] re, input logic [63:0] im,
                                             input int dw);
      logic [63:0] mask;
      mask = (64'd1 << (dw / 2)) - 64'd1;
      return (im << (dw / 2)) | (re & mask);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cfo_corrector_nco_lut.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nco_lut                                                              |
// | Registered quarter-free sin/cos ROM, one full turn over 2^ADDR words,|
// | amplitude 2^(LUT_DW-1)-1 so the most negative code never appears.   |
// | Ports: clk, addr (phase MSBs), cos_val / sin_val (1-cycle latency).  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module nco_lut #(
   parameter int LUT_ADDR_DW = 10,
   parameter int LUT_DW      = 16
) (
   input  logic                     clk,
   input  logic [LUT_ADDR_DW-1:0]   addr,
   output logic signed [LUT_DW-1:0] cos_val,
   output logic signed [LUT_DW-1:0] sin_val
);

   localparam int  DEPTH = 1 << LUT_ADDR_DW;
   localparam real AMP   = real'((2 ** (LUT_DW - 1)) - 1);

   // Round half away from zero.
   function automatic int round_int(input real x);
      return (x >= 0.0) ? $rtoi(x + 0.5) : $rtoi(x - 0.5);
   endfunction

   logic signed [LUT_DW-1:0] cos_rom [DEPTH];
   logic signed [LUT_DW-1:0] sin_rom [DEPTH];

   // Table contents are elaboration-time constants.
   for (genvar k = 0; k < DEPTH; k++) begin : g_rom
      localparam real ANG   = 6.283185307179586 * real'(k) / real'(DEPTH);
      localparam int  COS_V = round_int(AMP * $cos(ANG));
      localparam int  SIN_V = round_int(AMP * $sin(ANG));
      assign cos_rom[k] = LUT_DW'(COS_V);
      assign sin_rom[k] = LUT_DW'(SIN_V);
   end

   always_ff @(posedge clk) begin
      cos_val <= cos_rom[addr];
      sin_val <= sin_rom[addr];
   end

endmodule
`default_nettype wire

// File: rtl/cfo_corrector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cfo_corrector                                                        |
// | Turns a normalized CFO angle into a per-sample phase increment,      |
// | accumulates phase per valid sample and de-rotates the stream by      |
// | (cos + j sin) of the accumulated phase. 4-cycle latency, no stalls.  |
// | Ports: clk_i, reset_i (sync, active-high), CFO_norm_i/CFO_valid_i,   |
// | phase_reset_i, s_axis_in_*, m_axis_out_*, phase_o (debug).           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cfo_corrector
   import cfo_pkg::*;
#(
   parameter int IN_DW        = 32,
   parameter int OUT_DW       = 32,
   parameter int CFO_DW       = 20,
   parameter int CFO_LAG_LOG2 = 6,
   parameter int PHASE_DW     = 24,
   parameter int LUT_ADDR_DW  = 10,
   parameter int LUT_DW       = 16
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic [CFO_DW-1:0]   CFO_norm_i,
   input  logic                CFO_valid_i,
   input  logic                phase_reset_i,
   input  logic [IN_DW-1:0]    s_axis_in_tdata,
   input  logic                s_axis_in_tvalid,
   output logic [OUT_DW-1:0]   m_axis_out_tdata,
   output logic                m_axis_out_tvalid,
   output logic [PHASE_DW-1:0] phase_o
);

   localparam int IN_HW  = IN_DW / 2;
   localparam int OUT_HW = OUT_DW / 2;
   localparam int PW     = IN_HW + LUT_DW;  // product width
   localparam int SW     = PW + 1;          // sum / difference width

   localparam logic signed [SW-1:0] RND_BIAS = SW'(64'sd1 <<< (LUT_DW - 2));
   localparam logic signed [SW-1:0] SAT_MAX  = SW'((64'sd1 <<< (OUT_HW - 1)) - 64'sd1);
   localparam logic signed [SW-1:0] SAT_MIN  = ~SAT_MAX;

   function automatic logic [OUT_HW-1:0] sat(input logic signed [SW-1:0] v);
      if (v > SAT_MAX)      return SAT_MAX[OUT_HW-1:0];
      else if (v < SAT_MIN) return SAT_MIN[OUT_HW-1:0];
      else                  return v[OUT_HW-1:0];
   endfunction

   // Increment: negate the scaled angle (de-rotation), then divide by the lag.
   // The most negative angle negates to itself, which is pi and still valid.
   logic signed [PHASE_DW-1:0] cfo_scaled;
   logic signed [PHASE_DW-1:0] inc_next;

   always_comb begin
      cfo_scaled = PHASE_DW'(signed'(CFO_norm_i)) <<< (PHASE_DW - CFO_DW);
      inc_next   = (-cfo_scaled) >>> CFO_LAG_LOG2;
   end

   logic [PHASE_DW-1:0] inc;
   logic [PHASE_DW-1:0] acc;
   logic [PHASE_DW-1:0] acc_base;

   // Phase seen by the current sample; a phase reset takes effect immediately.
   assign acc_base = phase_reset_i ? '0 : acc;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         inc <= '0;
         acc <= '0;
      end else begin
         if (CFO_valid_i)
            inc <= inc_next;
         if (s_axis_in_tvalid)
            acc <= acc_base + inc;
         else
            acc <= acc_base;
      end
   end

   assign phase_o = acc;

   // Pipeline
   logic                     s0_valid, s1_valid, s2_valid;
   logic signed [IN_HW-1:0]  s0_re, s0_im, s1_re, s1_im;
   logic [LUT_ADDR_DW-1:0]   s0_addr;
   logic signed [LUT_DW-1:0] lut_cos, lut_sin;
   logic signed [PW-1:0]     p_rc, p_is, p_rs, p_ic;
   logic signed [SW-1:0]     sum_re, sum_im, rnd_re, rnd_im;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         s0_valid          <= 1'b0;
         s1_valid          <= 1'b0;
         s2_valid          <= 1'b0;
         m_axis_out_tvalid <= 1'b0;
      end else begin
         s0_valid          <= s_axis_in_tvalid;
         s1_valid          <= s0_valid;
         s2_valid          <= s1_valid;
         m_axis_out_tvalid <= s2_valid;
      end
   end

   always_ff @(posedge clk_i) begin
      s0_re   <= IN_HW'(cplx_re(64'(s_axis_in_tdata), IN_DW));
      s0_im   <= IN_HW'(cplx_im(64'(s_axis_in_tdata), IN_DW));
      s0_addr <= acc_base[PHASE_DW-1 -: LUT_ADDR_DW];
      s1_re   <= s0_re;
      s1_im   <= s0_im;
      p_rc    <= PW'(s1_re) * PW'(lut_cos);
      p_is    <= PW'(s1_im) * PW'(lut_sin);
      p_rs    <= PW'(s1_re) * PW'(lut_sin);
      p_ic    <= PW'(s1_im) * PW'(lut_cos);
   end

   nco_lut #(
      .LUT_ADDR_DW (LUT_ADDR_DW),
      .LUT_DW      (LUT_DW)
   ) u_nco_lut (
      .clk     (clk_i),
      .addr    (s0_addr),
      .cos_val (lut_cos),
      .sin_val (lut_sin)
   );

   always_comb begin
      sum_re = SW'(p_rc) - SW'(p_is);
      sum_im = SW'(p_rs) + SW'(p_ic);
      rnd_re = (sum_re + RND_BIAS) >>> (LUT_DW - 1);
      rnd_im = (sum_im + RND_BIAS) >>> (LUT_DW - 1);
   end

   // Data only moves with a valid sample, so it stays at 0 after reset.
   always_ff @(posedge clk_i) begin
      if (reset_i)
         m_axis_out_tdata <= '0;
      else if (s2_valid)
         m_axis_out_tdata <= OUT_DW'(cplx_pack(64'(sat(rnd_re)), 64'(sat(rnd_im)), OUT_DW));
   end

endmodule
`default_nettype wire

// File: tb/tb_cfo_corrector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cfo_corrector                                                     |
// | Directed vectors with hand-computed expectations for cfo_corrector.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_cfo_corrector;
   import cfo_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [19:0] cfo_norm = '0;
   logic        cfo_valid = 1'b0;
   logic        phase_reset = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic [31:0] out_data;
   logic        out_valid;
   logic [23:0] phase;

   logic signed [15:0] out_re, out_im;
   assign out_re = out_data[15:0];
   assign out_im = out_data[31:16];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cfo_corrector dut (
      .clk_i             (clk),
      .reset_i           (reset),
      .CFO_norm_i        (cfo_norm),
      .CFO_valid_i       (cfo_valid),
      .phase_reset_i     (phase_reset),
      .s_axis_in_tdata   (in_data),
      .s_axis_in_tvalid  (in_valid),
      .m_axis_out_tdata  (out_data),
      .m_axis_out_tvalid (out_valid),
      .phase_o           (phase)
   );

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic drive(input logic v, input int re, input int im);
      in_valid = v;
      in_data  = {16'(im), 16'(re)};
   endtask

   logic   pat [5]    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
   longint ph_gap [6] = '{'h000000, 'hFE0000, 'hFE0000, 'hFE0000, 'hFC0000, 'hFA0000};

   initial begin
      // Reset state
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_valid", longint'(out_valid), 0);
      check("rst_data",  longint'(out_data), 0);
      check("rst_phase", longint'(phase), 0);
      reset = 1'b0;

      // CFO = 0: pass-through, latency 4, 100 samples
      for (int n = 0; n <= 104; n++) begin
         @(negedge clk);
         check("t1_valid", longint'(out_valid), longint'(n >= 4 && n <= 103));
         if (n >= 4 && n <= 103) begin
            check("t1_re", out_re, 1000);
            check("t1_im", out_im, 2000);
         end
         if (n < 100) drive(1'b1, 1000, 2000);
         else         drive(1'b0, 0, 0);
      end

      // CFO = pi/2 per 64 samples after a phase reset, input 16000+j0
      @(negedge clk);
      cfo_norm    = 20'(PI_NORM / 2);
      cfo_valid   = 1'b1;
      phase_reset = 1'b1;
      for (int n = 0; n <= 68; n++) begin
         @(negedge clk);
         cfo_valid   = 1'b0;
         phase_reset = 1'b0;
         if (n == 0)  check("t2_ph0", longint'(phase), 0);
         if (n == 1)  check("t2_ph1", longint'(phase), 'hFF0000);
         if (n == 64) check("t2_ph64", longint'(phase), 'hC00000);
         if (n == 4) begin
            check("t2_s0_re", out_re, 16000);
            check("t2_s0_im", out_im, 0);
         end
         if (n == 36) begin
            check("t2_s32_re", out_re, 11313);
            check("t2_s32_im", out_im, -11313);
         end
         if (n == 68) begin
            check("t2_s64_v",  longint'(out_valid), 1);
            check("t2_s64_re", out_re, 0);
            check("t2_s64_im", out_im, -16000);
         end
         if (n <= 64) drive(1'b1, 16000, 0);
         else         drive(1'b0, 0, 0);
      end

      // Saturation at -pi/4, positive then negative full-scale input
      for (int s = 0; s < 2; s++) begin
         @(negedge clk);
         phase_reset = 1'b1;
         for (int n = 0; n <= 36; n++) begin
            @(negedge clk);
            phase_reset = 1'b0;
            if (n == 4) begin
               check("t3_s0_re", out_re, (s == 0) ? 32766 : -32766);
               check("t3_s0_im", out_im, (s == 0) ? 32766 : -32766);
            end
            if (n == 36) begin
               check("t3_s32_re", out_re, (s == 0) ? 32767 : -32768);
               check("t3_s32_im", out_im, 0);
            end
            if (n <= 32) drive(1'b1, (s == 0) ? 32767 : -32767, (s == 0) ? 32767 : -32767);
            else         drive(1'b0, 0, 0);
         end
      end

      // CFO update coincident with a sample; new CFO is the most negative code
      @(negedge clk);
      phase_reset = 1'b1;
      for (int n = 0; n <= 8; n++) begin
         @(negedge clk);
         phase_reset = 1'b0;
         cfo_valid   = 1'b0;
         if (n == 0) check("t4_ph0", longint'(phase), 'h000000);
         if (n == 1) check("t4_ph1", longint'(phase), 'hFF0000);
         if (n == 2) check("t4_ph2", longint'(phase), 'hFE0000);
         if (n == 3) check("t4_ph3", longint'(phase), 'hFC0000);
         if (n == 4) begin
            check("t4_ph4", longint'(phase), 'hFA0000);
            check("t4_s0_re", out_re, 16000);
            check("t4_s0_im", out_im, 0);
         end
         if (n == 1) begin
            cfo_valid = 1'b1;
            cfo_norm  = 20'(-PI_NORM);
         end
         if (n <= 3) drive(1'b1, 16000, 0);
         else        drive(1'b0, 0, 0);
      end

      // Gapped input 1-0-0-1-1
      @(negedge clk);
      phase_reset = 1'b1;
      for (int n = 0; n <= 9; n++) begin
         @(negedge clk);
         phase_reset = 1'b0;
         check("t5_phase", longint'(phase), ph_gap[(n < 5) ? n : 5]);
         check("t5_valid", longint'(out_valid), (n >= 4 && n <= 8) ? longint'(pat[(n >= 4 && n <= 8) ? n - 4 : 0]) : 0);
         if (n == 4) begin
            check("t5_s0_re", out_re, 1000);
            check("t5_s0_im", out_im, 2000);
         end
         if (n < 5) drive(pat[n], 1000, 2000);
         else       drive(1'b0, 0, 0);
      end

      // Reset with three samples in flight
      for (int n = 0; n <= 10; n++) begin
         @(negedge clk);
         reset = 1'b0;
         if (n == 4) begin
            check("t6_phase", longint'(phase), 0);
            check("t6_data",  longint'(out_data), 0);
         end
         if (n >= 4 && n <= 9) check("t6_novalid", longint'(out_valid), 0);
         if (n == 7) check("t6_ph_after", longint'(phase), 0);
         if (n == 10) begin
            check("t6_valid", longint'(out_valid), 1);
            check("t6_re", out_re, 1000);
            check("t6_im", out_im, 2000);
         end
         if (n == 3) reset = 1'b1;
         if (n <= 2 || n == 6) drive(1'b1, 1000, 2000);
         else                  drive(1'b0, 0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
